// File: rtl/secuenciador_escritura_rtc_pkg.sv
// Shared constants for the local-to-RTC write sequencer: modo encodings,
// RTC register addresses, FSM state encoding and the per-modo address range.
package secuenciador_escritura_rtc_pkg;

    localparam logic [1:0] MODO_TODO       = 2'b00;
    localparam logic [1:0] MODO_HORA_FECHA = 2'b01;
    localparam logic [1:0] MODO_TIMER      = 2'b10;
    localparam logic [1:0] MODO_INVALIDO   = 2'b11;

    localparam logic [7:0] RTC_TIEMPO_0 = 8'h21;
    localparam logic [7:0] RTC_TIEMPO_1 = 8'h22;
    localparam logic [7:0] RTC_TIEMPO_2 = 8'h23;
    localparam logic [7:0] RTC_TIEMPO_3 = 8'h24;
    localparam logic [7:0] RTC_TIEMPO_4 = 8'h25;
    localparam logic [7:0] RTC_TIEMPO_5 = 8'h26;
    localparam logic [7:0] RTC_TIEMPO_6 = 8'h27;
    localparam logic [7:0] RTC_TIMER_0  = 8'h41;
    localparam logic [7:0] RTC_TIMER_1  = 8'h42;
    localparam logic [7:0] RTC_TIMER_2  = 8'h43;
    localparam logic [7:0] RTC_COMMIT   = 8'hF1;

    localparam logic [2:0] EST_IDLE      = 3'd0;
    localparam logic [2:0] EST_CARGA     = 3'd1;
    localparam logic [2:0] EST_PEDIR     = 3'd2;
    localparam logic [2:0] EST_SIGUIENTE = 3'd3;
    localparam logic [2:0] EST_COMMIT    = 3'd4;
    localparam logic [2:0] EST_FIN       = 3'd5;

    typedef struct packed {
        logic [3:0] primera;
        logic [3:0] ultima;
    } rango_t;

    // Invalid modo yields a harmless 0..0 range; the FSM rejects it anyway.
    function automatic rango_t rango_modo(input logic [1:0] modo);
        rango_t r;
        case (modo)
            MODO_TODO:       r = '{primera: 4'd0, ultima: 4'd9};
            MODO_HORA_FECHA: r = '{primera: 4'd0, ultima: 4'd6};
            MODO_TIMER:      r = '{primera: 4'd7, ultima: 4'd9};
            default:         r = '{primera: 4'd0, ultima: 4'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/secuenciador_escritura_rtc_if.sv
// Write request channel between the sequencer (master) and the RTC bus driver (slave).
interface secuenciador_escritura_rtc_if;

    logic       req_escritura;
    logic       ack_escritura;
    logic [7:0] dir_rtc;
    logic [7:0] dato_rtc;

    modport master (
        output req_escritura,
        output dir_rtc,
        output dato_rtc,
        input  ack_escritura
    );

    modport slave (
        input  req_escritura,
        input  dir_rtc,
        input  dato_rtc,
        output ack_escritura
    );

endinterface

// File: rtl/secuenciador_escritura_rtc_mapa_dir_rtc.sv
// Combinational map from local register-file address to RTC register address.
module mapa_dir_rtc
    import secuenciador_escritura_rtc_pkg::*;
(
    input  logic [3:0] addr_local,
    output logic [7:0] dir_rtc
);

    always_comb begin
        dir_rtc = 8'h00;
        case (addr_local)
            4'd0: dir_rtc = RTC_TIEMPO_0;
            4'd1: dir_rtc = RTC_TIEMPO_1;
            4'd2: dir_rtc = RTC_TIEMPO_2;
            4'd3: dir_rtc = RTC_TIEMPO_3;
            4'd4: dir_rtc = RTC_TIEMPO_4;
            4'd5: dir_rtc = RTC_TIEMPO_5;
            4'd6: dir_rtc = RTC_TIEMPO_6;
            4'd7: dir_rtc = RTC_TIMER_0;
            4'd8: dir_rtc = RTC_TIMER_1;
            4'd9: dir_rtc = RTC_TIMER_2;
            default: dir_rtc = 8'h00;
        endcase
    end

endmodule

// File: rtl/secuenciador_escritura_rtc.sv
// Sweeps the local register file into the RTC, one req/ack write per register,
// and finishes with a commit write so the RTC latches the new values.
module secuenciador_escritura_rtc
    import secuenciador_escritura_rtc_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CICLOS = 16'd1000,
    parameter logic [7:0]  CMD_ADDR       = 8'hF1,
    parameter logic [7:0]  CMD_DATA       = 8'hF1
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    modo,
    input  logic [7:0]                    in_dato_mem,
    output logic                          reg_wr,
    output logic [3:0]                    addr_mem_local,
    output logic                          ocupado,
    output logic                          fin,
    output logic                          error,
    secuenciador_escritura_rtc_if.master  bus
);

    logic [2:0]  estado;
    logic [3:0]  ultima_dir;
    logic [15:0] contador;
    rango_t      rango;
    logic [3:0]  addr_siguiente;
    logic [7:0]  dir_siguiente;

    // One map instance serves both the first address (from IDLE) and each increment.
    always_comb begin
        rango          = rango_modo(modo);
        addr_siguiente = (estado == EST_IDLE) ? rango.primera : addr_mem_local + 4'd1;
    end

    mapa_dir_rtc u_mapa (
        .addr_local (addr_siguiente),
        .dir_rtc    (dir_siguiente)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado            <= EST_IDLE;
            reg_wr            <= 1'b1;
            addr_mem_local    <= 4'd0;
            ultima_dir        <= 4'd0;
            contador          <= 16'd0;
            ocupado           <= 1'b0;
            fin               <= 1'b0;
            error             <= 1'b0;
            bus.req_escritura <= 1'b0;
            bus.dir_rtc       <= 8'h00;
            bus.dato_rtc      <= 8'h00;
        end else begin
            fin   <= 1'b0;
            error <= 1'b0;
            case (estado)
                EST_IDLE: begin
                    reg_wr            <= 1'b1;
                    bus.req_escritura <= 1'b0;
                    if (start) begin
                        if (modo == MODO_INVALIDO) begin
                            error <= 1'b1;
                        end else begin
                            addr_mem_local <= addr_siguiente;
                            ultima_dir     <= rango.ultima;
                            bus.dir_rtc    <= dir_siguiente;
                            reg_wr         <= 1'b0;
                            ocupado        <= 1'b1;
                            estado         <= EST_CARGA;
                        end
                    end
                end
                EST_CARGA: begin
                    bus.dato_rtc      <= in_dato_mem;
                    bus.req_escritura <= 1'b1;
                    contador          <= 16'd0;
                    estado            <= EST_PEDIR;
                end
                // An ack sampled in the same cycle the counter hits the limit wins.
                EST_PEDIR, EST_COMMIT: begin
                    if (bus.ack_escritura) begin
                        bus.req_escritura <= 1'b0;
                        if (estado == EST_COMMIT) begin
                            fin    <= 1'b1;
                            estado <= EST_FIN;
                        end else begin
                            estado <= EST_SIGUIENTE;
                        end
                    end else if (contador == TIMEOUT_CICLOS) begin
                        bus.req_escritura <= 1'b0;
                        error             <= 1'b1;
                        ocupado           <= 1'b0;
                        reg_wr            <= 1'b1;
                        estado            <= EST_IDLE;
                    end else if (contador != 16'hFFFF) begin
                        contador <= contador + 16'd1;
                    end
                end
                EST_SIGUIENTE: begin
                    if (addr_mem_local == ultima_dir) begin
                        bus.dir_rtc       <= CMD_ADDR;
                        bus.dato_rtc      <= CMD_DATA;
                        bus.req_escritura <= 1'b1;
                        reg_wr            <= 1'b1;
                        contador          <= 16'd0;
                        estado            <= EST_COMMIT;
                    end else begin
                        addr_mem_local <= addr_siguiente;
                        bus.dir_rtc    <= dir_siguiente;
                        estado         <= EST_CARGA;
                    end
                end
                EST_FIN: begin
                    ocupado <= 1'b0;
                    estado  <= EST_IDLE;
                end
                default: begin
                    estado <= EST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_escritura_rtc.sv
// Scoreboard bench for secuenciador_escritura_rtc: stimulus queues expected writes
// and terminal events, a monitor pops and compares them as the DUT issues them.
module tb_secuenciador_escritura_rtc;

    typedef struct {
        logic [7:0] dir;
        logic [7:0] dato;
        logic       reg_wr;
        logic       chk_addr;
        logic [3:0] addr;
    } escritura_t;

    localparam int LAT_ACK = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start_stim;
    logic       start_ruido;
    logic [1:0] modo;
    logic [7:0] in_dato_mem;
    logic       reg_wr;
    logic [3:0] addr_mem_local;
    logic       ocupado;
    logic       fin;
    logic       error;
    logic       ack_bus;
    logic       ack_ruido;
    logic       ruido_activo;
    int         sin_ack_num;

    escritura_t wq[$];
    int         evq[$];
    int         checks_total;
    int         checks_passed;

    secuenciador_escritura_rtc_if bus_if ();

    secuenciador_escritura_rtc #(
        .TIMEOUT_CICLOS (16'd8),
        .CMD_ADDR       (8'hF1),
        .CMD_DATA       (8'hF1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .modo           (modo),
        .in_dato_mem    (in_dato_mem),
        .reg_wr         (reg_wr),
        .addr_mem_local (addr_mem_local),
        .ocupado        (ocupado),
        .fin            (fin),
        .error          (error),
        .bus            (bus_if.master)
    );

    // Local-to-RTC selector model: gated to zero when reg_wr is high.
    assign in_dato_mem          = reg_wr ? 8'h00 : (8'h10 + {4'h0, addr_mem_local});
    assign start                = start_stim | start_ruido;
    assign bus_if.ack_escritura = ack_bus | ack_ruido;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string nombre, input logic [15:0] actual, input logic [15:0] esperado);
        checks_total++;
        if (actual === esperado) checks_passed++;
        else $display("[TB] FAIL %s: got %h expected %h", nombre, actual, esperado);
    endtask

    task automatic fallo(input string nombre, input string detalle);
        checks_total++;
        $display("[TB] FAIL %s: %s", nombre, detalle);
    endtask

    function automatic logic [7:0] dir_esperada(input int a);
        case (a)
            0: return 8'h21;  1: return 8'h22;  2: return 8'h23;  3: return 8'h24;
            4: return 8'h25;  5: return 8'h26;  6: return 8'h27;  7: return 8'h41;
            8: return 8'h42;  9: return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_registro(input int a);
        escritura_t e;
        e.dir      = dir_esperada(a);
        e.dato     = 8'h10 + 8'(a);
        e.reg_wr   = 1'b0;
        e.chk_addr = 1'b1;
        e.addr     = 4'(a);
        wq.push_back(e);
    endtask

    task automatic push_commit();
        escritura_t e;
        e.dir      = 8'hF1;
        e.dato     = 8'hF1;
        e.reg_wr   = 1'b1;
        e.chk_addr = 1'b0;
        e.addr     = 4'd0;
        wq.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [1:0] m);
        @(posedge clk); #1;
        modo       = m;
        start_stim = 1'b1;
        @(posedge clk); #1;
        start_stim = 1'b0;
    endtask

    task automatic esperar_reposo(input string nombre, input int max_ciclos);
        int n;
        bit listo;
        n = 0;
        listo = 0;
        while (!listo && n < max_ciclos) begin
            @(negedge clk); #1;
            n++;
            listo = (wq.size() == 0) && (evq.size() == 0) && !ocupado && !bus_if.req_escritura;
        end
        if (!listo)
            fallo(nombre, $sformatf("not idle after %0d cycles, %0d writes and %0d events pending",
                                    max_ciclos, wq.size(), evq.size()));
        repeat (3) @(negedge clk);
    endtask

    // Bus driver model: acks each request LAT_ACK cycles after it rises, except the
    // request numbered sin_ack_num; optionally injects stray ack/start while busy.
    initial begin
        int espera;
        int num_req;
        ack_bus     = 1'b0;
        ack_ruido   = 1'b0;
        start_ruido = 1'b0;
        espera      = 0;
        num_req     = 0;
        forever begin
            @(posedge clk); #1;
            ack_bus     = 1'b0;
            ack_ruido   = 1'b0;
            start_ruido = 1'b0;
            if (!reset) begin
                espera  = 0;
                num_req = 0;
            end else begin
                if (!ocupado) num_req = 0;
                if (bus_if.req_escritura) begin
                    if (espera == 0) num_req++;
                    espera++;
                    if (espera == LAT_ACK && num_req != sin_ack_num) ack_bus = 1'b1;
                end else begin
                    espera = 0;
                    if (ruido_activo && ocupado) begin
                        ack_ruido   = 1'b1;
                        start_ruido = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: each rising req is one write; fin/error pulses are terminal events.
    initial begin
        logic req_prev;
        escritura_t e;
        int ev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                req_prev = 1'b0;
            end else begin
                if (bus_if.req_escritura && !req_prev) begin
                    if (wq.size() == 0) begin
                        fallo("write_unexpected", $sformatf("dir %h dato %h", bus_if.dir_rtc, bus_if.dato_rtc));
                    end else begin
                        e = wq.pop_front();
                        check_output("dir_rtc", 16'(bus_if.dir_rtc), 16'(e.dir));
                        check_output("dato_rtc", 16'(bus_if.dato_rtc), 16'(e.dato));
                        check_output("reg_wr_in_write", 16'(reg_wr), 16'(e.reg_wr));
                        if (e.chk_addr) check_output("addr_mem_local", 16'(addr_mem_local), 16'(e.addr));
                    end
                end
                if (fin) begin
                    if (evq.size() == 0) fallo("fin_unexpected", "fin pulse with no event expected");
                    else begin
                        ev = evq.pop_front();
                        check_output("event_fin", 16'd0, 16'(ev));
                    end
                end
                if (error) begin
                    if (evq.size() == 0) fallo("error_unexpected", "error pulse with no event expected");
                    else begin
                        ev = evq.pop_front();
                        check_output("event_error", 16'd1, 16'(ev));
                    end
                end
                req_prev = bus_if.req_escritura;
            end
        end
    end

    initial begin
        bit encontrado;
        int n;
        checks_total  = 0;
        checks_passed = 0;
        reset         = 1'b0;
        start_stim    = 1'b0;
        modo          = 2'b00;
        sin_ack_num   = 0;
        ruido_activo  = 1'b0;

        repeat (2) @(negedge clk);
        check_output("rst_reg_wr", 16'(reg_wr), 16'd1);
        check_output("rst_addr", 16'(addr_mem_local), 16'd0);
        check_output("rst_dir", 16'(bus_if.dir_rtc), 16'd0);
        check_output("rst_dato", 16'(bus_if.dato_rtc), 16'd0);
        check_output("rst_req", 16'(bus_if.req_escritura), 16'd0);
        check_output("rst_ocupado", 16'(ocupado), 16'd0);
        check_output("rst_fin", 16'(fin), 16'd0);
        check_output("rst_error", 16'(error), 16'd0);
        reset = 1'b1;

        $display("[TB] full sweep modo=00");
        for (int a = 0; a <= 9; a++) push_registro(a);
        push_commit();
        evq.push_back(0);
        apply_stimulus(2'b00);
        @(negedge clk);
        check_output("ocupado_after_start", 16'(ocupado), 16'd1);
        esperar_reposo("sweep_all", 200);

        $display("[TB] timer only modo=10");
        for (int a = 7; a <= 9; a++) push_registro(a);
        push_commit();
        evq.push_back(0);
        apply_stimulus(2'b10);
        esperar_reposo("sweep_timer", 100);

        $display("[TB] invalid modo=11");
        evq.push_back(1);
        apply_stimulus(2'b11);
        @(negedge clk);
        check_output("invalid_ocupado", 16'(ocupado), 16'd0);
        check_output("invalid_req", 16'(bus_if.req_escritura), 16'd0);
        @(negedge clk);
        check_output("invalid_ocupado_2", 16'(ocupado), 16'd0);
        esperar_reposo("invalid", 20);

        $display("[TB] timeout on third register");
        sin_ack_num = 3;
        for (int a = 0; a <= 2; a++) push_registro(a);
        evq.push_back(1);
        apply_stimulus(2'b01);
        esperar_reposo("timeout", 100);
        sin_ack_num = 0;

        $display("[TB] reset during register 4");
        for (int a = 0; a <= 4; a++) push_registro(a);
        apply_stimulus(2'b00);
        encontrado = 0;
        n = 0;
        while (!encontrado && n < 100) begin
            @(negedge clk); #1;
            n++;
            encontrado = (wq.size() == 0) && bus_if.req_escritura;
        end
        if (!encontrado) fallo("reset_wait", "request for register 4 never seen");
        reset = 1'b0;
        #1;
        check_output("midrst_req", 16'(bus_if.req_escritura), 16'd0);
        check_output("midrst_ocupado", 16'(ocupado), 16'd0);
        check_output("midrst_reg_wr", 16'(reg_wr), 16'd1);
        check_output("midrst_addr", 16'(addr_mem_local), 16'd0);
        check_output("midrst_dir", 16'(bus_if.dir_rtc), 16'd0);
        check_output("midrst_dato", 16'(bus_if.dato_rtc), 16'd0);
        repeat (2) @(negedge clk);
        wq.delete();
        reset = 1'b1;
        for (int a = 0; a <= 6; a++) push_registro(a);
        push_commit();
        evq.push_back(0);
        apply_stimulus(2'b01);
        esperar_reposo("after_reset", 150);

        $display("[TB] stray start/ack while busy");
        ruido_activo = 1'b1;
        for (int a = 7; a <= 9; a++) push_registro(a);
        push_commit();
        evq.push_back(0);
        apply_stimulus(2'b10);
        modo = 2'b00;
        esperar_reposo("spurious", 100);
        ruido_activo = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
